// File: rtl/rgb_pwm_pkg.sv
// Shared constants and types for the RGB PWM driver.
// Colour word layout is red in the top byte, blue in the bottom byte.
package rgb_pwm_pkg;

   localparam int          PWM_W   = 8;
   localparam logic [7:0]  CNT_MAX = 8'd254;

   localparam int R_HI = 23;
   localparam int R_LO = 16;
   localparam int G_HI = 15;
   localparam int G_LO = 8;
   localparam int B_HI = 7;
   localparam int B_LO = 0;

   typedef logic [PWM_W-1:0] duty_t;

endpackage

// File: rtl/rgb_pwm_driver_if.sv
// Colour load strobe in, PWM drive and frame pulse out.
// The converter side is the master; the driver is the slave.
interface rgb_pwm_driver_if;

   logic        enable;
   logic [23:0] rgb;
   logic        pwm_r;
   logic        pwm_g;
   logic        pwm_b;
   logic        frame_done;

   modport master (
      output enable,
      output rgb,
      input  pwm_r,
      input  pwm_g,
      input  pwm_b,
      input  frame_done
   );

   modport slave (
      input  enable,
      input  rgb,
      output pwm_r,
      output pwm_g,
      output pwm_b,
      output frame_done
   );

endinterface

// File: rtl/rgb_pwm_driver_pwm_channel.sv
// One PWM channel: active duty register, comparator and output flop.
// Define RGB_PWM_INVERT_EN for common-anode LEDs (output low = lit).
module pwm_channel
   import rgb_pwm_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  logic  load_i,
   input  duty_t duty_i,
   input  duty_t cnt_i,
   output logic  pwm_o
);

`ifdef RGB_PWM_INVERT_EN
   localparam logic IDLE_LVL = 1'b1;
`else
   localparam logic IDLE_LVL = 1'b0;
`endif

   duty_t active_q, active_d;
   logic  pwm_q, pwm_d;

   // The comparison uses the pre-load duty, so a new colour reaches the pin one clock after the wrap.
   always_comb begin
      active_d = load_i ? duty_i : active_q;
      pwm_d    = (cnt_i < active_q) ^ IDLE_LVL;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         active_q <= '0;
         pwm_q    <= IDLE_LVL;
      end else begin
         active_q <= active_d;
         pwm_q    <= pwm_d;
      end
   end

   assign pwm_o = pwm_q;

endmodule

// File: rtl/rgb_pwm_driver.sv
// RGB LED PWM driver with frame-aligned double buffering of the colour word.
// Optional macro RGB_PWM_INVERT_EN (in pwm_channel) inverts the three PWM outputs.
module rgb_pwm_driver
   import rgb_pwm_pkg::*;
#(
   parameter int PRESCALE = 4
)
(
   input  logic clk,
   input  logic rst,
   rgb_pwm_driver_if.slave io
);

   localparam int               PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

   logic [PRE_W-1:0] pre_q, pre_d;
   duty_t            cnt_q, cnt_d;
   logic [23:0]      pending_q, pending_d;
   logic             frameDone_q, frameDone_d;
   logic             tick;
   logic             wrap;

   // A frame is 255 count steps; the wrap tick is where the pending colour becomes active.
   always_comb begin
      tick        = (pre_q == PRE_LAST);
      wrap        = tick && (cnt_q == CNT_MAX);
      pre_d       = tick ? '0 : pre_q + PRE_W'(1);
      cnt_d       = cnt_q;
      if (tick) begin
         cnt_d = wrap ? '0 : cnt_q + 8'd1;
      end
      pending_d   = io.enable ? io.rgb : pending_q;
      frameDone_d = wrap;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre_q       <= '0;
         cnt_q       <= '0;
         pending_q   <= '0;
         frameDone_q <= 1'b0;
      end else begin
         pre_q       <= pre_d;
         cnt_q       <= cnt_d;
         pending_q   <= pending_d;
         frameDone_q <= frameDone_d;
      end
   end

   pwm_channel uRed (
      .clk    (clk),
      .rst    (rst),
      .load_i (wrap),
      .duty_i (pending_q[R_HI:R_LO]),
      .cnt_i  (cnt_q),
      .pwm_o  (io.pwm_r)
   );

   pwm_channel uGreen (
      .clk    (clk),
      .rst    (rst),
      .load_i (wrap),
      .duty_i (pending_q[G_HI:G_LO]),
      .cnt_i  (cnt_q),
      .pwm_o  (io.pwm_g)
   );

   pwm_channel uBlue (
      .clk    (clk),
      .rst    (rst),
      .load_i (wrap),
      .duty_i (pending_q[B_HI:B_LO]),
      .cnt_i  (cnt_q),
      .pwm_o  (io.pwm_b)
   );

   assign io.frame_done = frameDone_q;

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Directed scoreboard bench for rgb_pwm_driver at PRESCALE=1.
// Each expected frame (lit steps per channel) is queued when its colour is strobed.
module tb_rgb_pwm_driver;

`ifdef RGB_PWM_INVERT_EN
   localparam logic INV = 1'b1;
`else
   localparam logic INV = 1'b0;
`endif

   typedef struct {
      string tag;
      int    r;
      int    g;
      int    b;
   } exp_t;

   logic clk;
   logic rst;
   int   assertCount;
   int   failCount;
   exp_t sbQ[$];

   rgb_pwm_driver_if io ();

   rgb_pwm_driver #(.PRESCALE(1)) dut (
      .clk (clk),
      .rst (rst),
      .io  (io)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic exp_t mkExp(input string tag, input int r, input int g, input int b);
      exp_t e;
      e.tag = tag;
      e.r   = r;
      e.g   = g;
      e.b   = b;
      return e;
   endfunction

   function automatic int litOf(input logic p);
      return ((p ^ INV) === 1'b1) ? 1 : 0;
   endfunction

   task automatic checkOutput(input string tag, input int obs, input int expv);
      assertCount++;
      assert (obs === expv) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic applyStimulus(input logic en, input logic [23:0] val);
      io.enable = en;
      io.rgb    = val;
   endtask

   task automatic stepClk();
      @(posedge clk);
      #1;
   endtask

   // Runs from reset release to the first wrap, optionally strobing one colour.
   task automatic runFirstFrame(input string tag, input int strobeAt, input logic [23:0] val);
      int clocks = 0;
      int r = 0;
      int g = 0;
      int b = 0;
      while (clocks < 400) begin
         stepClk();
         clocks++;
         r += litOf(io.pwm_r);
         g += litOf(io.pwm_g);
         b += litOf(io.pwm_b);
         if (clocks == strobeAt) applyStimulus(1'b1, val);
         else                    applyStimulus(1'b0, 24'h0);
         if (io.frame_done === 1'b1) break;
      end
      checkOutput({tag, "_wrapClocks"}, clocks, 255);
      checkOutput({tag, "_litR"}, r, 0);
      checkOutput({tag, "_litG"}, g, 0);
      checkOutput({tag, "_litB"}, b, 0);
   endtask

   // Measures one full frame starting just after a wrap; index 253 strobes on the next wrap edge.
   task automatic measureFrame(input int s1, input logic [23:0] v1, input int s2, input logic [23:0] v2);
      exp_t e;
      int   r = 0;
      int   g = 0;
      int   b = 0;
      if (sbQ.size() == 0) begin
         assertCount++;
         failCount++;
         $error("[TB] FAIL sbEmpty: observed 0 entries expected at least 1");
         return;
      end
      e = sbQ.pop_front();
      for (int i = 0; i < 255; i++) begin
         stepClk();
         r += litOf(io.pwm_r);
         g += litOf(io.pwm_g);
         b += litOf(io.pwm_b);
         if (i == 0) begin
            checkOutput({e.tag, "_firstR"}, litOf(io.pwm_r), (e.r > 0) ? 1 : 0);
            checkOutput({e.tag, "_firstG"}, litOf(io.pwm_g), (e.g > 0) ? 1 : 0);
            checkOutput({e.tag, "_firstB"}, litOf(io.pwm_b), (e.b > 0) ? 1 : 0);
         end
         if (i == s1)      applyStimulus(1'b1, v1);
         else if (i == s2) applyStimulus(1'b1, v2);
         else              applyStimulus(1'b0, 24'h0);
      end
      checkOutput({e.tag, "_frameDone"}, int'(io.frame_done), 1);
      checkOutput({e.tag, "_litR"}, r, e.r);
      checkOutput({e.tag, "_litG"}, g, e.g);
      checkOutput({e.tag, "_litB"}, b, e.b);
   endtask

   initial begin
      exp_t e;
      assertCount = 0;
      failCount   = 0;
      rst         = 1'b1;
      applyStimulus(1'b0, 24'h0);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_pwmR", int'(io.pwm_r), int'(INV));
      checkOutput("reset_pwmG", int'(io.pwm_g), int'(INV));
      checkOutput("reset_pwmB", int'(io.pwm_b), int'(INV));
      checkOutput("reset_frameDone", int'(io.frame_done), 0);
      rst = 1'b0;

      $display("[TB] reset release, first frame with basic-duty strobe");
      sbQ.push_back(mkExp("basic", 255, 0, 128));
      runFirstFrame("frame0", 10, 24'hFF0080);

      sbQ.push_back(mkExp("noTear64", 64, 64, 64));
      measureFrame(50, 24'h404040, -1, 24'h0);

      sbQ.push_back(mkExp("noTear192", 192, 192, 192));
      measureFrame(100, 24'hC0C0C0, -1, 24'h0);

      $display("[TB] strobe on the wrap edge");
      sbQ.push_back(mkExp("collisionOld", 192, 192, 192));
      sbQ.push_back(mkExp("collisionNew", 1, 2, 3));
      measureFrame(253, 24'h010203, -1, 24'h0);
      measureFrame(-1, 24'h0, -1, 24'h0);

      $display("[TB] two strobes in one frame");
      sbQ.push_back(mkExp("lastWins", 32, 32, 32));
      measureFrame(20, 24'h101010, 60, 24'h202020);

      sbQ.push_back(mkExp("full", 255, 255, 255));
      measureFrame(5, 24'hFFFFFF, -1, 24'h0);

      $display("[TB] reset in the middle of a full-white frame");
      e = sbQ.pop_front();
      repeat (100) stepClk();
      checkOutput("midFrame_pwmR", litOf(io.pwm_r), (100 < e.r) ? 1 : 0);
      sbQ.push_back(mkExp("afterReset", 0, 0, 0));
      applyStimulus(1'b0, 24'h0);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("asyncRst_pwmR", int'(io.pwm_r), int'(INV));
      checkOutput("asyncRst_pwmG", int'(io.pwm_g), int'(INV));
      checkOutput("asyncRst_pwmB", int'(io.pwm_b), int'(INV));
      checkOutput("asyncRst_frameDone", int'(io.frame_done), 0);
      checkOutput("asyncRst_cnt", int'(dut.cnt_q), 0);
      checkOutput("asyncRst_pending", int'(dut.pending_q), 0);
      stepClk();
      rst = 1'b0;
      runFirstFrame("rstFrame", -1, 24'h0);
      measureFrame(-1, 24'h0, -1, 24'h0);

      $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
